// File: rtl/wb_regfile_if.sv
// MEM/WB write-back and ID read-port signal bundle for wb_regfile.
// master = pipeline side driving control/data/indices; slave = the register file.
interface wb_regfile_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 16
) ();
    logic                   WB_RegWrite_In;
    logic                   WB_MemtoReg_In;
    logic [DATA_WIDTH-1:0]  WB_ReadData_In;
    logic [DATA_WIDTH-1:0]  WB_ALUresult_In;
    logic [ADDR_WIDTH-1:0]  WB_Index_WriteReg_In;
    logic [ADDR_WIDTH-1:0]  ID_ReadReg1_In;
    logic [ADDR_WIDTH-1:0]  ID_ReadReg2_In;
    logic [DATA_WIDTH-1:0]  ID_ReadData1_Out;
    logic [DATA_WIDTH-1:0]  ID_ReadData2_Out;
    logic [DATA_WIDTH-1:0]  WB_WriteData_Out;
    logic                   WB_WriteValid_Out;
    logic [COUNT_WIDTH-1:0] WB_RetireCount_Out;

    modport master (
        output WB_RegWrite_In, WB_MemtoReg_In, WB_ReadData_In, WB_ALUresult_In,
        output WB_Index_WriteReg_In, ID_ReadReg1_In, ID_ReadReg2_In,
        input  ID_ReadData1_Out, ID_ReadData2_Out, WB_WriteData_Out,
        input  WB_WriteValid_Out, WB_RetireCount_Out
    );

    modport slave (
        input  WB_RegWrite_In, WB_MemtoReg_In, WB_ReadData_In, WB_ALUresult_In,
        input  WB_Index_WriteReg_In, ID_ReadReg1_In, ID_ReadReg2_In,
        output ID_ReadData1_Out, ID_ReadData2_Out, WB_WriteData_Out,
        output WB_WriteValid_Out, WB_RetireCount_Out
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select + 32-entry register file; 1-edge write, combinational reads with write-through bypass.
// No backpressure: a write presented with RegWrite is always committed on the next edge.
module wb_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Entry 0 is hardwired to zero, so storage starts at index 1.
    logic [DATA_WIDTH-1:0]  regs [1:DEPTH-1];
    logic [DATA_WIDTH-1:0]  wb_dat;
    logic                   wb_vld;
    logic [ADDR_WIDTH-1:0]  wb_idx;
    logic [COUNT_WIDTH-1:0] retire_cnt;
    logic [DATA_WIDTH-1:0]  rd1_dat;
    logic [DATA_WIDTH-1:0]  rd2_dat;

    assign wb_idx = bus.WB_Index_WriteReg_In;
    assign wb_dat = bus.WB_MemtoReg_In ? bus.WB_ReadData_In : bus.WB_ALUresult_In;
    // RegWrite gates everything, so unknown index/data during a bubble cannot leak into state.
    assign wb_vld = bus.WB_RegWrite_In & (wb_idx != '0);

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] ra);
        logic [DATA_WIDTH-1:0] res;
        res = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (ra == ADDR_WIDTH'(i)) begin
                res = (wb_vld && ra == wb_idx) ? wb_dat : regs[i];
            end
        end
        return res;
    endfunction

    always_comb begin
        rd1_dat = read_port(bus.ID_ReadReg1_In);
        rd2_dat = read_port(bus.ID_ReadReg2_In);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wb_vld && wb_idx == ADDR_WIDTH'(i)) begin
                    regs[i] <= wb_dat;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (wb_vld) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end

    assign bus.ID_ReadData1_Out   = rd1_dat;
    assign bus.ID_ReadData2_Out   = rd2_dat;
    assign bus.WB_WriteData_Out   = wb_dat;
    assign bus.WB_WriteValid_Out  = wb_vld;
    assign bus.WB_RetireCount_Out = retire_cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus queues expected outputs, a negedge monitor compares them.
module tb_wb_regfile;
    logic clk;
    logic reset;

    wb_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .COUNT_WIDTH(16)) bus ();

    wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .COUNT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam int SEL_RD1 = 0, SEL_RD2 = 1, SEL_WDAT = 2, SEL_WVLD = 3, SEL_CNT = 4;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are settled mid-cycle, so every queued expectation is resolved at negedge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.sel)
                SEL_RD1:  act = bus.ID_ReadData1_Out;
                SEL_RD2:  act = bus.ID_ReadData2_Out;
                SEL_WDAT: act = bus.WB_WriteData_Out;
                SEL_WVLD: act = {31'd0, bus.WB_WriteValid_Out};
                default:  act = {16'd0, bus.WB_RetireCount_Out};
            endcase
            n_checks++;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit with %0d checks queued", sbq.size());
        $fatal(1, "watchdog");
    end

    task automatic expect_out(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] rdat,
                         input logic [31:0] alu, input logic [4:0] idx,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.WB_RegWrite_In       = we;
        bus.WB_MemtoReg_In       = m2r;
        bus.WB_ReadData_In       = rdat;
        bus.WB_ALUresult_In      = alu;
        bus.WB_Index_WriteReg_In = idx;
        bus.ID_ReadReg1_In       = r1;
        bus.ID_ReadReg2_In       = r2;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        step();
        step();
        expect_out("cnt_in_reset", SEL_CNT, 32'd0);
        step();
        reset = 1'b0;

        // Every index reads 0 on both ports after reset.
        for (int i = 0; i < 32; i++) begin
            step();
            drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
            expect_out($sformatf("rst_rd1_%0d", i), SEL_RD1, 32'h0);
            expect_out($sformatf("rst_rd2_%0d", 31 - i), SEL_RD2, 32'h0);
        end
        expect_out("rst_cnt", SEL_CNT, 32'd0);

        // ALU path write to r5.
        step();
        drive(1'b1, 1'b0, 32'hCAFEF00D, 32'h12345678, 5'd5, 5'd1, 5'd2);
        expect_out("alu_wdat", SEL_WDAT, 32'h12345678);
        expect_out("alu_wvld", SEL_WVLD, 32'd1);
        expect_out("alu_cnt_before", SEL_CNT, 32'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        expect_out("alu_rd1_r5", SEL_RD1, 32'h12345678);
        expect_out("alu_cnt", SEL_CNT, 32'd1);

        // Memory path write to r31.
        step();
        drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h00000001, 5'd31, 5'd0, 5'd0);
        expect_out("mem_wdat", SEL_WDAT, 32'hDEADBEEF);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd31);
        expect_out("mem_rd2_r31", SEL_RD2, 32'hDEADBEEF);
        expect_out("mem_cnt", SEL_CNT, 32'd2);

        // Bypass: r7 = 0x11, then overwrite with 0xAA while both ports read r7.
        step();
        drive(1'b1, 1'b0, 32'h0, 32'h00000011, 5'd7, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
        expect_out("byp_pre_rd1", SEL_RD1, 32'h11);
        expect_out("byp_pre_rd2", SEL_RD2, 32'h11);
        expect_out("byp_pre_cnt", SEL_CNT, 32'd3);
        step();
        drive(1'b1, 1'b0, 32'h0, 32'h000000AA, 5'd7, 5'd7, 5'd7);
        expect_out("byp_rd1", SEL_RD1, 32'hAA);
        expect_out("byp_rd2", SEL_RD2, 32'hAA);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
        expect_out("byp_post_rd1", SEL_RD1, 32'hAA);
        expect_out("byp_post_rd2", SEL_RD2, 32'hAA);
        expect_out("byp_post_cnt", SEL_CNT, 32'd4);

        // Only port 1 hits the bypass; port 2 keeps reading storage.
        step();
        drive(1'b1, 1'b1, 32'h00000055, 32'hFFFF0000, 5'd5, 5'd5, 5'd31);
        expect_out("byp1_rd1", SEL_RD1, 32'h55);
        expect_out("byp1_rd2", SEL_RD2, 32'hDEADBEEF);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd5);
        expect_out("byp1_post_rd1", SEL_RD1, 32'hDEADBEEF);
        expect_out("byp1_post_rd2", SEL_RD2, 32'h55);
        expect_out("byp1_cnt", SEL_CNT, 32'd5);

        // Zero register: write is discarded, not counted, and not bypassed.
        step();
        drive(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        expect_out("z_rd1", SEL_RD1, 32'h0);
        expect_out("z_rd2", SEL_RD2, 32'h0);
        expect_out("z_wvld", SEL_WVLD, 32'd0);
        expect_out("z_wdat", SEL_WDAT, 32'hFFFFFFFF);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        expect_out("z_post_rd1", SEL_RD1, 32'h0);
        expect_out("z_post_cnt", SEL_CNT, 32'd5);

        // Bubble with unknown payload must leave storage and count alone.
        step();
        drive(1'b0, 1'b1, 32'hxxxxxxxx, 32'hxxxxxxxx, 5'bxxxxx, 5'd5, 5'd7);
        expect_out("bub_wvld", SEL_WVLD, 32'd0);
        expect_out("bub_rd1", SEL_RD1, 32'h55);
        expect_out("bub_rd2", SEL_RD2, 32'hAA);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7);
        expect_out("bub_post_rd1", SEL_RD1, 32'h55);
        expect_out("bub_post_rd2", SEL_RD2, 32'hAA);
        expect_out("bub_post_cnt", SEL_CNT, 32'd5);

        // Three more commits, then async reset between edges with a write pending.
        for (int i = 1; i <= 3; i++) begin
            step();
            drive(1'b1, 1'b0, 32'h0, 32'h100 + 32'(i), 5'(i), 5'd0, 5'd0);
        end
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd2, 5'd3);
        expect_out("pre_rst_rd1", SEL_RD1, 32'h102);
        expect_out("pre_rst_cnt", SEL_CNT, 32'd8);
        step();
        #2;
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 32'h00000099, 5'd9, 5'd5, 5'd31);
        expect_out("arst_cnt", SEL_CNT, 32'd0);
        expect_out("arst_rd1", SEL_RD1, 32'h0);
        expect_out("arst_rd2", SEL_RD2, 32'h0);
        step();
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd1);
        expect_out("rel_rd1_r9", SEL_RD1, 32'h0);
        expect_out("rel_rd2_r1", SEL_RD2, 32'h0);
        expect_out("rel_cnt", SEL_CNT, 32'd0);

        // First edge after release commits normally.
        step();
        drive(1'b1, 1'b0, 32'h0, 32'h00000022, 5'd2, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd2, 5'd0);
        expect_out("first_rd1", SEL_RD1, 32'h22);
        expect_out("first_cnt", SEL_CNT, 32'd1);

        // Counter wrap: bring the count from 1 to 0xFFFF, then one more write rolls to 0.
        for (int i = 0; i < 65534; i++) begin
            step();
            drive(1'b1, 1'b0, 32'h0, 32'(i), 5'd4, 5'd0, 5'd0);
        end
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
        expect_out("wrap_full_cnt", SEL_CNT, 32'h0000FFFF);
        expect_out("wrap_rd1_r4", SEL_RD1, 32'd65533);
        step();
        drive(1'b1, 1'b0, 32'h0, 32'h00000044, 5'd4, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
        expect_out("wrap_cnt", SEL_CNT, 32'h00000000);
        expect_out("wrap_post_rd1", SEL_RD1, 32'h44);

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
